hazard_control: RTL and testbench
=================================

// Module: hazard_control
// PURPOSE
//  Hazard detection and forwarding controller; produces the stall/flush/forward controls that the
//  decode/execute pipeline register and the PC/fetch-decode registers consume.
//  Compares decode-stage source regs against EX/MEM/WB destinations, generates decode-stage WB
//  bypass (forwardC/D) and EX operand selects, and sequences load-use stalls, redirect flushes and halt.
// PARAMETERS
//  REG_AW             5  register address width
//  LOAD_STALL_CYCLES  1  bubbles inserted per load-use hazard (>=1)
//  FLUSH_CYCLES       1  cycles flush_fd/bubble_fe stay high after a redirect (>=1)
// PORTS
//  clk            in   1      clock, all state on posedge
//  rst            in   1      synchronous, active-high reset
//  id_read_reg1   in   REG_AW decode-stage rs1
//  id_read_reg2   in   REG_AW decode-stage rs2
//  id_hlt         in   1      hlt decoded in decode stage
//  ex_read_reg1   in   REG_AW rs1 held in decode/execute register
//  ex_read_reg2   in   REG_AW rs2 held in decode/execute register
//  ex_write_reg   in   REG_AW EX destination; ex_reg_write in 1; ex_mem_reg in 1 (EX op is a load)
//  ex_redirect    in   1      taken branch/jal/jalr resolved in EX
//  mem_write_reg  in   REG_AW MEM destination; mem_reg_write in 1
//  wb_write_reg   in   REG_AW WB destination;  wb_reg_write  in 1
//  forward_c      out  1      decode rs1 takes WB write data (to in_forwardC)
//  forward_d      out  1      decode rs2 takes WB write data (to in_forwardD)
//  forward_a      out  2      EX operand1 select: 00 reg, 01 MEM result, 10 WB data
//  forward_b      out  2      EX operand2 select, same encoding
//  stall_pc       out  1      hold PC;  stall_fd out 1 hold fetch/decode register
//  bubble_fe      out  1      load zero control (reg_write,mem_write,branch,jal,jalr=0) into decode/execute reg
//  flush_fd       out  1      invalidate fetch/decode register;  halted out 1 processor frozen
// BEHAVIOUR
//  - Register x0 never matches: any compare with address 0 is false.
//  - forward_c = wb_reg_write & wb_write_reg==id_read_reg1; forward_d likewise for rs2. Combinational.
//  - forward_a/b: MEM match (mem_reg_write) wins over WB match; else 00. Combinational on ex_* inputs.
//  - load_use = ex_reg_write & ex_mem_reg & (ex_write_reg==id_read_reg1 | ex_write_reg==id_read_reg2).
//  - FSM states RUN, STALL, FLUSH, HALT; down-counter cnt, width $clog2(max(params)+1).
//  - RUN, priority ex_redirect > load_use > id_hlt:
//     redirect: flush_fd=1,bubble_fe=1 this cycle; FLUSH_CYCLES>1 -> FLUSH, cnt=FLUSH_CYCLES-1.
//     load_use: stall_pc=stall_fd=bubble_fe=1 this cycle; LOAD_STALL_CYCLES>1 -> STALL, cnt=N-1.
//     id_hlt: stall_pc=stall_fd=bubble_fe=1 this cycle, -> HALT.
//  - STALL: stall_pc/stall_fd/bubble_fe=1; cnt-- ; cnt==1 -> RUN. ex_redirect here aborts stall:
//    outputs become flush pattern, -> RUN (or FLUSH per FLUSH_CYCLES).
//  - FLUSH: flush_fd=bubble_fe=1; cnt--; cnt==1 -> RUN. New ex_redirect reloads cnt.
//  - HALT: stall_pc=stall_fd=bubble_fe=halted=1 every cycle; left only via rst.
//  - Stall and flush never both high: flush wins, stall outputs forced 0 when flushing.
//  - Reset (any state, any cycle): state=RUN, cnt=0, all outputs 0 (forward masked during rst).
//  - Forward outputs remain live in STALL/FLUSH; they are don't-care when bubble_fe=1.
// STRUCTURE
//  - hazard_pkg: state enum {RUN,STALL,FLUSH,HALT}; FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
//  - One sub-module fwd_select (rs, mem/wb dest+valid -> 2-bit select), instanced for forward_a/b.
//  - FSM + counter in top; stall/flush outputs from one always_comb on state and hazard terms.
// TESTING
//  - ex: lw x5 (ex_mem_reg=1,ex_write_reg=5), id_read_reg1=5 -> stall_pc/stall_fd/bubble_fe=1 one cycle, then 0.
//  - id_read_reg2=0, ex load to x0 -> no stall; wb_write_reg=0 wb_reg_write=1 -> forward_d=0.
//  - mem_write_reg=7 and wb_write_reg=7 both valid, ex_read_reg1=7 -> forward_a=01; MEM invalid -> 10.
//  - ex_redirect and load_use same cycle -> flush_fd=1,bubble_fe=1, stall_pc=0; FLUSH_CYCLES=2 -> flush 2 cycles.
//  - id_hlt -> halted=1 held 20 cycles regardless of inputs; rst high 1 cycle -> all outputs 0 next cycle.
//  - LOAD_STALL_CYCLES=3, rst asserted in 2nd stall cycle -> state RUN, stalls drop after that edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard detection / forwarding controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2,
      ST_HALT  = 2'd3
   } hz_state_e;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // Larger of two sequence lengths; sizes the shared down-counter.
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fwd_select.sv
// EX operand bypass select: the youngest in-flight writer (MEM) wins over WB.
module fwd_select
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] mem_write_reg,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] wb_write_reg,
   input  logic              wb_reg_write,
   output logic [1:0]        sel
);

   logic mem_hit_s;
   logic wb_hit_s;

   // x0 is hard-wired zero, so a zero source never takes a bypass.
   assign mem_hit_s = mem_reg_write & (rs != {REG_AW{1'b0}}) & (mem_write_reg == rs);
   assign wb_hit_s  = wb_reg_write  & (rs != {REG_AW{1'b0}}) & (wb_write_reg  == rs);

   // Priority select between the two bypass sources.
   always_comb begin
      sel = FWD_REG;
      if (mem_hit_s) begin
         sel = FWD_MEM;
      end else if (wb_hit_s) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_REG;
      end
   end

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: WB/EX bypass selects plus the load-use stall,
// redirect flush and halt sequencer driving the PC and pipeline registers.
module hazard_control
   import hazard_pkg::*;
#(
   parameter int REG_AW            = 5,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_read_reg1,
   input  logic [REG_AW-1:0] id_read_reg2,
   input  logic              id_hlt,
   input  logic [REG_AW-1:0] ex_read_reg1,
   input  logic [REG_AW-1:0] ex_read_reg2,
   input  logic [REG_AW-1:0] ex_write_reg,
   input  logic              ex_reg_write,
   input  logic              ex_mem_reg,
   input  logic              ex_redirect,
   input  logic [REG_AW-1:0] mem_write_reg,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] wb_write_reg,
   input  logic              wb_reg_write,
   output logic              forward_c,
   output logic              forward_d,
   output logic [1:0]        forward_a,
   output logic [1:0]        forward_b,
   output logic              stall_pc,
   output logic              stall_fd,
   output logic              bubble_fe,
   output logic              flush_fd,
   output logic              halted
);

   localparam int CNT_W = $clog2(max2(LOAD_STALL_CYCLES, FLUSH_CYCLES) + 1);
   localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
   localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};

   hz_state_e         state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [1:0]        fwd_a_s;
   logic [1:0]        fwd_b_s;
   logic              load_use_s;
   logic              stall_s;
   logic              flush_s;
   logic              halted_s;

   fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
      .rs            (ex_read_reg1),
      .mem_write_reg (mem_write_reg),
      .mem_reg_write (mem_reg_write),
      .wb_write_reg  (wb_write_reg),
      .wb_reg_write  (wb_reg_write),
      .sel           (fwd_a_s)
   );

   fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
      .rs            (ex_read_reg2),
      .mem_write_reg (mem_write_reg),
      .mem_reg_write (mem_reg_write),
      .wb_write_reg  (wb_write_reg),
      .wb_reg_write  (wb_reg_write),
      .sel           (fwd_b_s)
   );

   assign forward_a = rst ? FWD_REG : fwd_a_s;
   assign forward_b = rst ? FWD_REG : fwd_b_s;
   assign forward_c = ~rst & wb_reg_write & (wb_write_reg != REG_ZERO) & (wb_write_reg == id_read_reg1);
   assign forward_d = ~rst & wb_reg_write & (wb_write_reg != REG_ZERO) & (wb_write_reg == id_read_reg2);

   // A load into x0 produces nothing to wait for.
   assign load_use_s = ex_reg_write & ex_mem_reg & (ex_write_reg != REG_ZERO) &
                       ((ex_write_reg == id_read_reg1) | (ex_write_reg == id_read_reg2));

   // Sequencer state and bubble/flush down-counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_RUN;
         cnt_r   <= CNT_ZERO;
      end else begin
         case (state_r)
            ST_RUN, ST_STALL, ST_FLUSH: begin
               if (ex_redirect) begin
                  state_r <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                  cnt_r   <= (FLUSH_CYCLES > 1) ? FLUSH_LOAD : CNT_ZERO;
               end else if (state_r != ST_RUN) begin
                  if (cnt_r <= CNT_ONE) begin
                     state_r <= ST_RUN;
                     cnt_r   <= CNT_ZERO;
                  end else begin
                     cnt_r   <= cnt_r - CNT_ONE;
                  end
               end else if (load_use_s) begin
                  state_r <= (LOAD_STALL_CYCLES > 1) ? ST_STALL : ST_RUN;
                  cnt_r   <= (LOAD_STALL_CYCLES > 1) ? STALL_LOAD : CNT_ZERO;
               end else if (id_hlt) begin
                  state_r <= ST_HALT;
                  cnt_r   <= CNT_ZERO;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_HALT: begin
               state_r <= ST_HALT;
            end
            default: begin
               state_r <= ST_RUN;
               cnt_r   <= CNT_ZERO;
            end
         endcase
      end
   end

   // Stall/flush decode; a redirect always overrides a stall so the two never overlap.
   always_comb begin
      stall_s  = 1'b0;
      flush_s  = 1'b0;
      halted_s = 1'b0;
      if (rst) begin
         stall_s  = 1'b0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (ex_redirect) begin
                  flush_s = 1'b1;
               end else begin
                  stall_s = load_use_s | id_hlt;
               end
            end
            ST_STALL: begin
               if (ex_redirect) begin
                  flush_s = 1'b1;
               end else begin
                  stall_s = 1'b1;
               end
            end
            ST_FLUSH: begin
               flush_s = 1'b1;
            end
            ST_HALT: begin
               stall_s  = 1'b1;
               halted_s = 1'b1;
            end
            default: begin
               stall_s = 1'b0;
            end
         endcase
      end
   end

   assign stall_pc  = stall_s;
   assign stall_fd  = stall_s;
   assign flush_fd  = flush_s;
   assign bubble_fe = stall_s | flush_s;
   assign halted    = halted_s;

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control: one default instance and one with
// LOAD_STALL_CYCLES=3 / FLUSH_CYCLES=2 driven from the same stimulus.
module tb_hazard_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_read_reg1, id_read_reg2, ex_read_reg1, ex_read_reg2;
   logic [4:0] ex_write_reg, mem_write_reg, wb_write_reg;
   logic       id_hlt, ex_reg_write, ex_mem_reg, ex_redirect, mem_reg_write, wb_reg_write;

   logic       d_fc, d_fd, d_sp, d_sf, d_bf, d_ff, d_h;
   logic [1:0] d_fa, d_fb;
   logic       p_fc, p_fd, p_sp, p_sf, p_bf, p_ff, p_h;
   logic [1:0] p_fa, p_fb;
   logic [10:0] d_out, p_out;

   int n_checks = 0;
   int n_fail   = 0;

   // Observation layout: {fa[1:0], fb[1:0], fc, fd, stall_pc, stall_fd, bubble_fe, flush_fd, halted}
   localparam logic [10:0] O_IDLE  = 11'b00_00_0_0_0_0_0_0_0;
   localparam logic [10:0] O_STALL = 11'b00_00_0_0_1_1_1_0_0;
   localparam logic [10:0] O_FLUSH = 11'b00_00_0_0_0_0_1_1_0;
   localparam logic [10:0] O_HALT  = 11'b00_00_0_0_1_1_1_0_1;

   assign d_out = {d_fa, d_fb, d_fc, d_fd, d_sp, d_sf, d_bf, d_ff, d_h};
   assign p_out = {p_fa, p_fb, p_fc, p_fd, p_sp, p_sf, p_bf, p_ff, p_h};

   always #5 clk = ~clk;

   hazard_control u_dut (
      .clk(clk), .rst(rst),
      .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2), .id_hlt(id_hlt),
      .ex_read_reg1(ex_read_reg1), .ex_read_reg2(ex_read_reg2), .ex_write_reg(ex_write_reg),
      .ex_reg_write(ex_reg_write), .ex_mem_reg(ex_mem_reg), .ex_redirect(ex_redirect),
      .mem_write_reg(mem_write_reg), .mem_reg_write(mem_reg_write),
      .wb_write_reg(wb_write_reg), .wb_reg_write(wb_reg_write),
      .forward_c(d_fc), .forward_d(d_fd), .forward_a(d_fa), .forward_b(d_fb),
      .stall_pc(d_sp), .stall_fd(d_sf), .bubble_fe(d_bf), .flush_fd(d_ff), .halted(d_h)
   );

   hazard_control #(.REG_AW(5), .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2)) u_dut_p (
      .clk(clk), .rst(rst),
      .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2), .id_hlt(id_hlt),
      .ex_read_reg1(ex_read_reg1), .ex_read_reg2(ex_read_reg2), .ex_write_reg(ex_write_reg),
      .ex_reg_write(ex_reg_write), .ex_mem_reg(ex_mem_reg), .ex_redirect(ex_redirect),
      .mem_write_reg(mem_write_reg), .mem_reg_write(mem_reg_write),
      .wb_write_reg(wb_write_reg), .wb_reg_write(wb_reg_write),
      .forward_c(p_fc), .forward_d(p_fd), .forward_a(p_fa), .forward_b(p_fb),
      .stall_pc(p_sp), .stall_fd(p_sf), .bubble_fe(p_bf), .flush_fd(p_ff), .halted(p_h)
   );

   task automatic check_eq(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      id_read_reg1 = 5'd0; id_read_reg2 = 5'd0; id_hlt = 1'b0;
      ex_read_reg1 = 5'd0; ex_read_reg2 = 5'd0; ex_write_reg = 5'd0;
      ex_reg_write = 1'b0; ex_mem_reg = 1'b0; ex_redirect = 1'b0;
      mem_write_reg = 5'd0; mem_reg_write = 1'b0;
      wb_write_reg = 5'd0; wb_reg_write = 1'b0;
   endtask

   task automatic load_ex(input logic [4:0] rd);
      ex_reg_write = 1'b1; ex_mem_reg = 1'b1; ex_write_reg = rd;
   endtask

   // Move to the next cycle's input window (inputs then settle before #1 sampling).
   task automatic next_cycle();
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      // Reset masks forwards even with live matches present.
      repeat (2) begin
         next_cycle();
         wb_reg_write = 1'b1; wb_write_reg = 5'd3; id_read_reg1 = 5'd3;
         mem_reg_write = 1'b1; mem_write_reg = 5'd4; ex_read_reg1 = 5'd4;
         #1;
         check_eq("reset_mask_d", d_out, O_IDLE);
         check_eq("reset_mask_p", p_out, O_IDLE);
      end

      next_cycle(); rst = 1'b0;
      wb_reg_write = 1'b1; wb_write_reg = 5'd3; id_read_reg1 = 5'd3;
      mem_reg_write = 1'b1; mem_write_reg = 5'd4; ex_read_reg1 = 5'd4;
      #1;
      check_eq("fwd_c_mem_a", d_out, 11'b01_00_1_0_0_0_0_0_0);

      next_cycle();
      wb_reg_write = 1'b1; wb_write_reg = 5'd0;
      #1;
      check_eq("fwd_x0_wb", d_out, O_IDLE);

      next_cycle();
      mem_reg_write = 1'b1; mem_write_reg = 5'd7; wb_reg_write = 1'b1; wb_write_reg = 5'd7;
      ex_read_reg1 = 5'd7; ex_read_reg2 = 5'd7; id_read_reg1 = 5'd7;
      #1;
      check_eq("fwd_mem_wins", d_out, 11'b01_01_1_0_0_0_0_0_0);
      mem_reg_write = 1'b0;
      #1;
      check_eq("fwd_wb_only", d_out, 11'b10_10_1_0_0_0_0_0_0);
      check_eq("fwd_wb_only_p", p_out, 11'b10_10_1_0_0_0_0_0_0);

      next_cycle();
      load_ex(5'd0);
      #1;
      check_eq("load_x0_nostall", d_out, O_IDLE);
      ex_mem_reg = 1'b0; ex_write_reg = 5'd5; id_read_reg1 = 5'd5;
      #1;
      check_eq("alu_nostall", d_out, O_IDLE);

      // Load-use: 1 bubble on default, 3 on the parameterised instance.
      next_cycle(); load_ex(5'd5); id_read_reg1 = 5'd5;
      #1;
      check_eq("lu_c0_d", d_out, O_STALL);
      check_eq("lu_c0_p", p_out, O_STALL);
      next_cycle(); #1;
      check_eq("lu_c1_d", d_out, O_IDLE);
      check_eq("lu_c1_p", p_out, O_STALL);
      next_cycle(); #1;
      check_eq("lu_c2_p", p_out, O_STALL);
      next_cycle(); #1;
      check_eq("lu_c3_p", p_out, O_IDLE);
      check_eq("lu_c3_d", d_out, O_IDLE);

      // Redirect coinciding with load-use: flush wins.
      next_cycle(); load_ex(5'd5); id_read_reg1 = 5'd5; ex_redirect = 1'b1;
      #1;
      check_eq("rd_lu_d", d_out, O_FLUSH);
      check_eq("rd_lu_p", p_out, O_FLUSH);
      next_cycle(); #1;
      check_eq("rd_c1_d", d_out, O_IDLE);
      check_eq("rd_c1_p", p_out, O_FLUSH);
      next_cycle(); #1;
      check_eq("rd_c2_p", p_out, O_IDLE);

      // Reset during the second stall cycle ends the stall.
      next_cycle(); load_ex(5'd9); id_read_reg2 = 5'd9;
      #1;
      check_eq("rst_lu_p", p_out, O_STALL);
      next_cycle(); rst = 1'b1;
      #1;
      check_eq("rst_mid_p", p_out, O_IDLE);
      next_cycle(); rst = 1'b0;
      #1;
      check_eq("rst_after_p", p_out, O_IDLE);
      check_eq("rst_after_d", d_out, O_IDLE);

      // Redirect aborts an ongoing stall.
      next_cycle(); load_ex(5'd5); id_read_reg1 = 5'd5;
      #1;
      check_eq("ab_c0_p", p_out, O_STALL);
      next_cycle(); ex_redirect = 1'b1;
      #1;
      check_eq("ab_c1_p", p_out, O_FLUSH);
      check_eq("ab_c1_d", d_out, O_FLUSH);
      next_cycle(); #1;
      check_eq("ab_c2_p", p_out, O_FLUSH);
      check_eq("ab_c2_d", d_out, O_IDLE);
      next_cycle(); #1;
      check_eq("ab_c3_p", p_out, O_IDLE);

      // Halt: entered on id_hlt, then frozen regardless of inputs.
      next_cycle(); id_hlt = 1'b1;
      #1;
      check_eq("hlt_c0_d", d_out, O_STALL);
      check_eq("hlt_c0_p", p_out, O_STALL);
      for (int i = 0; i < 20; i++) begin
         next_cycle();
         ex_redirect = i[0];
         load_ex(5'd5); id_read_reg1 = 5'd5;
         #1;
         check_eq("halt_hold_d", d_out, O_HALT);
         check_eq("halt_hold_p", p_out, O_HALT);
      end
      next_cycle(); rst = 1'b1;
      #1;
      check_eq("halt_rst_d", d_out, O_IDLE);
      next_cycle(); rst = 1'b0;
      #1;
      check_eq("halt_exit_d", d_out, O_IDLE);
      check_eq("halt_exit_p", p_out, O_IDLE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
